// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// A borrow flip-flop carries the borrow between cycles; done pulses for one cycle.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bn;
  logic [WIDTH-1:0] diff_shift;

  // One full-subtractor cell, applied to the current LSBs.
  assign d  = a_sr[0] ^ b_sr[0] ^ brw;
  assign bn = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);

  // The result fills from the top so that after WIDTH shifts bit 0 sits at diff[0].
  generate
    if (WIDTH == 1) begin : g_shift_one
      assign diff_shift = d;
    end else begin : g_shift_many
      assign diff_shift = {d, diff[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: registers are always assigned with <= so every flop samples pre-edge values.
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all datapath registers are reset so outputs never carry X after reset.
      a_sr <= '0;
      b_sr <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            brw  <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          diff <= diff_shift;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          brw  <= bn;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) bout <= bn;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: stimulus pushes expected results, monitors pop on done.
// Covers a WIDTH=8 instance with directed vectors and a WIDTH=1 instance truth table.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  serial_sub #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_sub #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [8:0] q8[$];
  logic [1:0] q1[$];
  int         done8_t[$];
  int         done8_cnt = 0;
  int         done1_cnt = 0;
  logic       prev_done8 = 1'b0;
  logic       prev_done1 = 1'b0;
  logic [8:0] e8;
  logic [1:0] e1;

  // {bout, diff} indexed by {a, b, bin}
  logic [1:0] tt1 [8] = '{2'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      done8_cnt++;
      done8_t.push_back(cyc);
      check("u8_done_single", {31'd0, prev_done8}, 0);
      if (q8.size() == 0) begin
        check("u8_unexpected_done", 1, 0);
      end else begin
        e8 = q8.pop_front();
        check("u8_diff", {24'd0, diff8}, {24'd0, e8[7:0]});
        check("u8_bout", {31'd0, bout8}, {31'd0, e8[8]});
      end
    end
    prev_done8 = done8;
    if (done1) begin
      done1_cnt++;
      check("u1_done_single", {31'd0, prev_done1}, 0);
      if (q1.size() == 0) begin
        check("u1_unexpected_done", 1, 0);
      end else begin
        e1 = q1.pop_front();
        check("u1_diff", {31'd0, diff1}, {31'd0, e1[0]});
        check("u1_bout", {31'd0, bout1}, {31'd0, e1[1]});
      end
    end
    prev_done1 = done1;
  end

  task automatic wait_idle8();
    int n = 0;
    while (busy8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("u8_idle_timeout", {31'd0, busy8}, 0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] ed, input logic eb);
    int nb = 0;
    int c0;
    int dc0;
    wait_idle8();
    dc0 = done8_cnt;
    c0  = cyc;
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    q8.push_back({eb, ed});
    @(negedge clk);
    start8 = 1'b0;
    while (busy8 && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    check("u8_busy_cycles", nb, 9);
    repeat (3) @(negedge clk);
    check("u8_done_count", done8_cnt - dc0, 1);
    if (done8_cnt != dc0) check("u8_latency", done8_t[$] - c0, 9);
    check("u8_diff_hold", {24'd0, diff8}, {24'd0, ed});
    check("u8_bout_hold", {31'd0, eb ? bout8 : bout8}, {31'd0, eb});
  endtask

  task automatic run1(input int idx);
    int nb = 0;
    int dc0;
    logic [2:0] v;
    v = idx[2:0];
    dc0 = done1_cnt;
    a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
    q1.push_back(tt1[idx]);
    @(negedge clk);
    start1 = 1'b0;
    while (busy1 && nb < 10) begin
      nb++;
      @(negedge clk);
    end
    check("u1_busy_cycles", nb, 2);
    check("u1_done_count", done1_cnt - dc0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    int dc0;

    // Reset state
    #12;
    check("rst_busy8", {31'd0, busy8}, 0);
    check("rst_done8", {31'd0, done8}, 0);
    check("rst_diff8", {24'd0, diff8}, 0);
    check("rst_bout8", {31'd0, bout8}, 0);
    check("rst_busy1", {31'd0, busy1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy8", {31'd0, busy8}, 0);
    check("post_rst_diff8", {24'd0, diff8}, 0);

    // Basic subtraction
    run8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);

    // Held start: back-to-back operations every WIDTH+2 cycles
    wait_idle8();
    t0 = done8_t.size();
    a8 = 8'h10; b8 = 8'h0F; bin8 = 1'b1; start8 = 1'b1;
    repeat (3) q8.push_back({1'b0, 8'h00});
    n = 0;
    while (done8_t.size() < t0 + 3 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    start8 = 1'b0;
    check("held_done_count", done8_t.size() - t0, 3);
    if (done8_t.size() >= t0 + 3) begin
      check("held_spacing_1", done8_t[t0+1] - done8_t[t0], 10);
      check("held_spacing_2", done8_t[t0+2] - done8_t[t0+1], 10);
    end
    @(negedge clk);
    wait_idle8();

    // Start while busy is ignored
    dc0 = done8_cnt;
    a8 = 8'hA5; b8 = 8'h5A; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back({1'b0, 8'h4B});
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_idle8();
    repeat (12) @(negedge clk);
    check("ignored_done_count", done8_cnt - dc0, 1);
    check("ignored_diff", {24'd0, diff8}, 32'h4B);

    // Borrow-out boundaries
    run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run8(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);

    // Reset in the middle of RUN (cnt=4)
    wait_idle8();
    dc0 = done8_cnt;
    a8 = 8'hC3; b8 = 8'h35; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_run_busy", {31'd0, busy8}, 1);
    check("mid_run_bout_held", {31'd0, bout8}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy8}, 0);
    check("mid_rst_done", {31'd0, done8}, 0);
    check("mid_rst_diff", {24'd0, diff8}, 0);
    check("mid_rst_bout", {31'd0, bout8}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_rst_no_done", done8_cnt - dc0, 0);
    run8(8'hC3, 8'h35, 1'b0, 8'h8E, 1'b0);

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) run1(i);

    repeat (3) @(negedge clk);
    check("u8_queue_empty", q8.size(), 0);
    check("u1_queue_empty", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
